// File: rtl/mem_read_arbiter_pkg.sv
// Shared types and constants for the memory read arbiter.
// Optional feature macro used by the top: MEM_ARB_STATS_EN.
// ADDR_WIDTH / DATA_WIDTH macros set the default bus widths (32 if undefined).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = `ADDR_WIDTH;
  localparam int unsigned DATA_W_DEF = `DATA_WIDTH;
  localparam int unsigned LEN_W_DEF  = 4;
  localparam int unsigned ID_W_DEF   = 4;
  localparam int unsigned STAT_W     = 32;

  localparam int unsigned REQ_ICACHE = 0;
  localparam int unsigned REQ_DCACHE = 1;
  localparam int unsigned NUM_REQ    = 2;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ADDR, ARB_DATA} arb_state_t;

  // Saturating increment for statistics counters.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/mem_read_arbiter_rr_pick2.sv
// Two-way round-robin winner select (combinational).
// Ports:
//   valid    in  [2]  per-requester request valid
//   rr_ptr   in  1    requester that wins when both are valid
//   any_c    out 1    at least one request valid
//   winner_c out 1    winning requester index
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid,
  input  logic               rr_ptr,
  output logic               any_c,
  output logic               winner_c
);

  assign any_c    = |valid;
  // A lone requester wins regardless of the pointer.
  assign winner_c = (&valid) ? rr_ptr : valid[REQ_DCACHE];

endmodule

// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one AXI-style memory read channel between the
// I-cache (req 0) and D-cache (req 1) refill masters. One transaction
// outstanding; grant held from address phase through the last data beat.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   s_arvalid/s_araddr/s_arlen/s_arid  per-requester address channel in
//   s_arready                       per-requester address accept
//   s_rvalid/s_rdata/s_rready       per-requester data channel (shared data bus)
//   m_ar*/m_arready                 address channel to memory
//   m_rvalid/m_rdata/m_rready       data channel from memory
//   stat_grants/stat_wait           only with MEM_ARB_STATS_EN: saturating
//                                   completed-transaction and wait-cycle counters
// ARLEN counts beats (not len-1); len 0 completes at address accept.
module mem_read_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF,
  parameter int unsigned ID_W   = ID_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             s_arvalid,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] s_araddr,
  input  logic [NUM_REQ-1:0][LEN_W-1:0]  s_arlen,
  input  logic [NUM_REQ-1:0][ID_W-1:0]   s_arid,
  output logic [NUM_REQ-1:0]             s_arready,
  output logic [NUM_REQ-1:0]             s_rvalid,
  output logic [DATA_W-1:0]              s_rdata,
  input  logic [NUM_REQ-1:0]             s_rready,
  output logic                           m_arvalid,
  output logic [ADDR_W-1:0]              m_araddr,
  output logic [LEN_W-1:0]               m_arlen,
  output logic [ID_W-1:0]                m_arid,
  input  logic                           m_arready,
  input  logic                           m_rvalid,
  input  logic [DATA_W-1:0]              m_rdata,
  output logic                           m_rready
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][STAT_W-1:0] stat_grants,
  output logic [NUM_REQ-1:0][STAT_W-1:0] stat_wait
`endif
);

  arb_state_t          state_q, state_d;
  logic                rr_ptr_q, rr_ptr_d;
  logic                grant_q, grant_d;
  logic [LEN_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                pick_any_c;
  logic                pick_win_c;

  rr_pick2 u_pick (
    .valid    (s_arvalid),
    .rr_ptr   (rr_ptr_q),
    .any_c    (pick_any_c),
    .winner_c (pick_win_c)
  );

  // Latched request fields drive the memory address channel directly.
  assign m_araddr = addr_q;
  assign m_arlen  = len_q;
  assign m_arid   = id_q;
  assign s_rdata  = m_rdata;

  // Next-state and channel steering.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    addr_d     = addr_q;
    len_d      = len_q;
    id_d       = id_q;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    s_arready  = '0;
    s_rvalid   = '0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any_c) begin
          grant_d = pick_win_c;
          addr_d  = s_araddr[pick_win_c];
          len_d   = s_arlen[pick_win_c];
          id_d    = s_arid[pick_win_c];
          state_d = ARB_ADDR;
        end
      end
      ARB_ADDR: begin
        m_arvalid          = 1'b1;
        s_arready[grant_q] = m_arready;
        if (m_arready) begin
          beat_cnt_d = len_q;
          if (len_q == '0) begin
            // Zero-length request completes at address accept.
            state_d  = ARB_IDLE;
            rr_ptr_d = ~grant_q;
          end else begin
            state_d = ARB_DATA;
          end
        end
      end
      ARB_DATA: begin
        s_rvalid[grant_q] = m_rvalid;
        m_rready          = s_rready[grant_q];
        if (m_rvalid && s_rready[grant_q]) begin
          beat_cnt_d = beat_cnt_q - LEN_W'(1);
          if (beat_cnt_q == LEN_W'(1)) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = ~grant_q;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State and latched-request registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= 1'b0;
      grant_q    <= 1'b0;
      beat_cnt_q <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      id_q       <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      id_q       <= id_d;
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic done_c;

  // A transaction completes on zero-length accept or on its last beat.
  assign done_c = ((state_q == ARB_ADDR) && m_arready && (len_q == '0)) ||
                  ((state_q == ARB_DATA) && m_rvalid && s_rready[grant_q] &&
                   (beat_cnt_q == LEN_W'(1)));

  // Saturating grant / wait statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_grants <= '0;
      stat_wait   <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (done_c && (grant_q == 1'(i))) begin
          stat_grants[i] <= sat_inc(stat_grants[i]);
        end
        if (s_arvalid[i] && !s_arready[i]) begin
          stat_wait[i] <= sat_inc(stat_wait[i]);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Self-checking bench for mem_read_arbiter: transaction-level model compared
// every cycle, plus literal expectations per directed scenario.
module tb_mem_read_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW = ADDR_W_DEF;
  localparam int unsigned DW = DATA_W_DEF;
  localparam int unsigned LW = LEN_W_DEF;
  localparam int unsigned IW = ID_W_DEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]         s_arvalid;
  logic [1:0][AW-1:0] s_araddr;
  logic [1:0][LW-1:0] s_arlen;
  logic [1:0][IW-1:0] s_arid;
  logic [1:0]         s_arready;
  logic [1:0]         s_rvalid;
  logic [DW-1:0]      s_rdata;
  logic [1:0]         s_rready;
  logic               m_arvalid;
  logic [AW-1:0]      m_araddr;
  logic [LW-1:0]      m_arlen;
  logic [IW-1:0]      m_arid;
  logic               m_arready;
  logic               m_rvalid;
  logic [DW-1:0]      m_rdata;
  logic               m_rready;
`ifdef MEM_ARB_STATS_EN
  logic [1:0][31:0]   stat_grants;
  logic [1:0][31:0]   stat_wait;
`endif

  mem_read_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arid(s_arid),
    .s_arready(s_arready), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rready(s_rready),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arid(m_arid),
    .m_arready(m_arready), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rready(m_rready)
`ifdef MEM_ARB_STATS_EN
    , .stat_grants(stat_grants), .stat_wait(stat_wait)
`endif
  );

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int            own = -1;    // requester owning the channel, -1 when free
  bit            sent = 1'b0; // address already accepted by memory
  int            left = 0;    // beats still to deliver
  int            prio = 0;    // requester that wins a tie
  logic [AW-1:0] mdl_addr = '0;
  int            mdl_len = 0;
  int            mdl_id = 0;
  bit            mdl_ok = 1'b0;

  function automatic int pick_of(input logic [1:0] v, input int p);
    if (v == 2'b11) return p;
    return v[1] ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      own <= -1; sent <= 1'b0; left <= 0; prio <= 0; mdl_ok <= 1'b1;
    end else if (mdl_ok) begin
      if (own < 0) begin
        if (s_arvalid != 2'b00) begin
          own      <= pick_of(s_arvalid, prio);
          mdl_addr <= s_araddr[pick_of(s_arvalid, prio)];
          mdl_len  <= int'(s_arlen[pick_of(s_arvalid, prio)]);
          mdl_id   <= int'(s_arid[pick_of(s_arvalid, prio)]);
          sent     <= 1'b0;
        end
      end else if (!sent) begin
        if (m_arready) begin
          if (mdl_len == 0) begin
            prio <= 1 - own; own <= -1;
          end else begin
            sent <= 1'b1; left <= mdl_len;
          end
        end
      end else if (m_rvalid && s_rready[own]) begin
        left <= left - 1;
        if (left == 1) begin
          prio <= 1 - own; own <= -1; sent <= 1'b0;
        end
      end
    end
  end

  logic       exp_arvalid;
  logic [1:0] exp_arready;
  logic [1:0] exp_rvalid;
  logic       exp_rready;
  assign exp_arvalid = (own >= 0) && !sent;
  assign exp_arready = {(own == 1) && !sent && m_arready, (own == 0) && !sent && m_arready};
  assign exp_rvalid  = {(own == 1) && sent && m_rvalid, (own == 0) && sent && m_rvalid};
  assign exp_rready  = sent && (((own == 0) && s_rready[0]) || ((own == 1) && s_rready[1]));

  // ---------------- compare + monitor ----------------
  int            beats[2]    = '{0, 0};
  int            last_bc[2]  = '{0, 0};
  int            arr_cyc[2]  = '{0, 0};
  logic [AW-1:0] rec_addr[2];
  int            stalls = 0;
  int            gq[$];

  initial forever begin
    @(negedge clk);
    if (mdl_ok) begin
      check("m_arvalid", 64'(m_arvalid), 64'(exp_arvalid));
      check("s_arready", 64'(s_arready), 64'(exp_arready));
      check("s_rvalid",  64'(s_rvalid),  64'(exp_rvalid));
      check("m_rready",  64'(m_rready),  64'(exp_rready));
      check("s_rdata",   64'(s_rdata),   64'(m_rdata));
      if (exp_arvalid) begin
        check("m_araddr", 64'(m_araddr), 64'(mdl_addr));
        check("m_arlen",  64'(m_arlen),  64'(mdl_len));
        check("m_arid",   64'(m_arid),   64'(mdl_id));
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (s_arready[i]) begin
        gq.push_back(i); rec_addr[i] = m_araddr; arr_cyc[i] = cyc;
      end
      if (s_rvalid[i] && s_rready[i]) begin
        beats[i]++; last_bc[i] = cyc;
      end
      if (s_rvalid[i] && !m_rready) stalls++;
    end
  end

  // ---------------- memory responder ----------------
  int ar_delay = 0;
  bit rv_en = 1'b1;
  initial begin
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    forever begin
      int ar_wait;
      @(posedge clk); #1;
      ar_wait   = m_arvalid ? ar_wait + 1 : 0;
      m_arready = m_arvalid && (ar_wait > ar_delay);
      m_rvalid  = rv_en;
      m_rdata   = DW'($urandom);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick(1); rst_n = 1'b1;
  endtask

  // Raise a request and hold it until accepted (bounded).
  task automatic request(input int i, input logic [AW-1:0] a, input int len, input int id);
    s_araddr[i] = a; s_arlen[i] = LW'(len); s_arid[i] = IW'(id); s_arvalid[i] = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (s_arready[i]) begin
        @(posedge clk); #1;
        s_arvalid[i] = 1'b0;
        return;
      end
    end
    check("arready_timeout", 64'(s_arready[i]), 64'd1);
    s_arvalid[i] = 1'b0;
  endtask

  initial begin
    int b0, b1, gs;
    s_arvalid = '0; s_araddr = '0; s_arlen = '0; s_arid = '0; s_rready = 2'b11;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    check("rst_m_arvalid", 64'(m_arvalid), 64'd0);
    check("rst_s_arready", 64'(s_arready), 64'd0);
    check("rst_s_rvalid",  64'(s_rvalid),  64'd0);
    check("rst_m_rready",  64'(m_rready),  64'd0);

    // Single requester, delayed address accept.
    ar_delay = 2; b0 = beats[0]; b1 = beats[1];
    request(0, AW'('h100), 4, 3);
    tick(6);
    check("t1_addr",   64'(rec_addr[0]), 64'h100);
    check("t1_beats0", 64'(beats[0] - b0), 64'd4);
    check("t1_beats1", 64'(beats[1] - b1), 64'd0);
    check("t1_idle",   64'({m_arvalid, s_rvalid}), 64'd0);

    // Simultaneous requests after reset: 0, 1, then 0 again.
    ar_delay = 0; do_reset(); gs = gq.size();
    fork
      request(0, AW'('h200), 2, 1);
      request(1, AW'('h300), 1, 2);
    join
    tick(3);
    fork
      request(0, AW'('h240), 1, 4);
      request(1, AW'('h340), 1, 5);
    join
    tick(3);
    check("t2_ngrants", 64'(gq.size() - gs), 64'd4);
    check("t2_g0", 64'(gq[gs]),     64'd0);
    check("t2_g1", 64'(gq[gs + 1]), 64'd1);
    check("t2_g2", 64'(gq[gs + 2]), 64'd0);
    check("t2_g3", 64'(gq[gs + 3]), 64'd1);

    // Requester stalls beat 2 of 4.
    b0 = beats[0]; gs = stalls;
    request(0, AW'('h400), 4, 5);
    tick(1);
    s_rready[0] = 1'b0;
    tick(1);
    s_rready[0] = 1'b1;
    tick(4);
    check("t3_beats0", 64'(beats[0] - b0), 64'd4);
    check("t3_stalls", 64'(stalls - gs), 64'd1);

    // req1 arrives mid-DATA of req0.
    fork
      request(0, AW'('h500), 4, 6);
      begin tick(3); request(1, AW'('h600), 2, 7); end
    join
    tick(4);
    check("t4_gap", 64'(arr_cyc[1] - last_bc[0]), 64'd2);
    check("t4_addr1", 64'(rec_addr[1]), 64'h600);

    // Zero-length request completes at address accept and moves the pointer.
    do_reset(); gs = gq.size();
    request(0, AW'('h700), 0, 1);
    fork
      request(0, AW'('h710), 1, 2);
      request(1, AW'('h720), 1, 3);
    join
    tick(3);
    check("t5_g0", 64'(gq[gs]),     64'd0);
    check("t5_g1", 64'(gq[gs + 1]), 64'd1);
    check("t5_g2", 64'(gq[gs + 2]), 64'd0);

    // Reset during beat 2; pointer returns to req0.
    request(0, AW'('h800), 4, 2);
    tick(1);
    rst_n = 1'b0;
    tick(1);
    check("t6_rst_arvalid", 64'(m_arvalid), 64'd0);
    check("t6_rst_rvalid",  64'(s_rvalid),  64'd0);
    rst_n = 1'b1; gs = gq.size(); b1 = beats[1];
    fork
      request(0, AW'('h900), 1, 3);
      request(1, AW'('hA00), 2, 4);
    join
    tick(4);
    check("t6_g0", 64'(gq[gs]), 64'd0);
    check("t6_beats1", 64'(beats[1] - b1), 64'd2);

    // req1 waits 7 cycles, then completes.
    do_reset(); ar_delay = 6; b1 = beats[1];
    request(1, AW'('hB00), 2, 3);
    tick(4);
    check("t7_beats1", 64'(beats[1] - b1), 64'd2);
`ifdef MEM_ARB_STATS_EN
    check("t7_stat_wait1",   64'(stat_wait[1]),   64'd7);
    check("t7_stat_grants1", 64'(stat_grants[1]), 64'd1);
    check("t7_stat_grants0", 64'(stat_grants[0]), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
